// File: rtl/input_fifo_unpack.sv
// Single-clock FWFT input FIFO that stores IN_WIDTH-bit words and delivers
// each one as RATIO narrower OUT_WIDTH-bit slices. The data path is a
// synchronous-read RAM, then a prefetch register (the RAM read port), then
// the holding register whose slices are presented on a registered dout.
module input_fifo_unpack #(
  parameter int IN_WIDTH            = 16,
  parameter int RATIO               = 2,
  parameter int DEPTH_LOG2          = 11,
  parameter int PROG_FULL_THRESHOLD = 1024,
  parameter bit LSB_FIRST           = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       din,
  input  logic                      wr_en,
  output logic                      full,
  output logic                      almost_full,
  output logic                      prog_full,
  output logic [DEPTH_LOG2:0]       count,
  input  logic                      rd_en,
  output logic [IN_WIDTH/RATIO-1:0] dout,
  output logic                      empty
);

  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int DEPTH     = 2 ** DEPTH_LOG2;
  localparam int CW        = DEPTH_LOG2 + 1;
  localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]    AFULL_C  = CW'(DEPTH - 1);
  localparam logic [CW-1:0]    PFULL_C  = CW'(PROG_FULL_THRESHOLD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Storage and pipeline state.
  logic [IN_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         ram_cnt;
  logic [IN_WIDTH-1:0]   ram_q;
  logic                  ram_q_valid;
  logic [IN_WIDTH-1:0]   hold;
  logic [IDX_W-1:0]      idx;

  // Per-edge decisions and next-state values.
  logic                  wr_acc;
  logic                  rd_fire;
  logic                  retire;
  logic                  load_hold;
  logic                  fetch;
  logic                  empty_n;
  logic [IDX_W-1:0]      idx_n;
  logic [IN_WIDTH-1:0]   hold_n;
  logic [OUT_WIDTH-1:0]  dout_n;
  logic [CW-1:0]         count_n;

  // Handshake decisions: the holding register refills from the prefetch
  // register when it is empty or its last slice leaves this edge, and the
  // prefetch register refills from RAM whenever it is empty or being drained,
  // which keeps output slices flowing without a bubble between words.
  always_comb begin
    wr_acc    = wr_en & ~full & ~rst;
    rd_fire   = rd_en & ~empty & ~rst;
    retire    = rd_fire & (idx == LAST_IDX);
    load_hold = (empty | retire) & ram_q_valid;
    fetch     = ~rst & (~ram_q_valid | load_hold) & (ram_cnt != '0);
  end

  // Next output state: slice index, holding word, registered dout slice and
  // the occupancy count (a word counts until its final slice is read).
  always_comb begin
    empty_n = empty;
    idx_n   = idx;
    hold_n  = hold;
    dout_n  = '0;
    count_n = count + CW'(wr_acc) - CW'(retire);

    if (rd_fire) begin
      idx_n = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
    if (retire) begin
      empty_n = 1'b1;
    end
    if (load_hold) begin
      hold_n  = ram_q;
      idx_n   = '0;
      empty_n = 1'b0;
    end

    for (int k = 0; k < RATIO; k++) begin
      if (idx_n == IDX_W'(k)) begin
        dout_n = hold_n[(LSB_FIRST ? k : RATIO - 1 - k) * OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // RAM write port and synchronous read port into the prefetch register.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
    if (fetch) begin
      ram_q <= mem[rd_ptr];
    end
  end

  // RAM-side pointers, RAM occupancy and the prefetch valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      ram_q_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_cnt     <= ram_cnt + CW'(wr_acc) - CW'(fetch);
      ram_q_valid <= fetch | (ram_q_valid & ~load_hold);
    end
  end

  // Output stage and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      idx         <= '0;
      empty       <= 1'b1;
      dout        <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      prog_full   <= 1'b0;
    end else begin
      hold        <= hold_n;
      idx         <= idx_n;
      empty       <= empty_n;
      dout        <= dout_n;
      count       <= count_n;
      full        <= (count_n == DEPTH_C);
      almost_full <= (count_n >= AFULL_C);
      prog_full   <= (count_n >= PFULL_C);
    end
  end

endmodule

// File: tb/tb_input_fifo_unpack.sv
// Testbench for input_fifo_unpack: two instances (LSB-first and MSB-first)
// share one stimulus stream and are compared against a word-queue model.
module tb_input_fifo_unpack;

  localparam int IW    = 16;
  localparam int R     = 2;
  localparam int OW    = IW / R;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 8;

  logic          clk;
  logic          rst;
  logic [IW-1:0] din;
  logic          wr_en;
  logic          rd_en;

  logic          full_a, af_a, pf_a, empty_a;
  logic [DL2:0]  count_a;
  logic [OW-1:0] dout_a;
  logic          full_b, af_b, pf_b, empty_b;
  logic [DL2:0]  count_b;
  logic [OW-1:0] dout_b;

  input_fifo_unpack #(
    .IN_WIDTH(IW), .RATIO(R), .DEPTH_LOG2(DL2),
    .PROG_FULL_THRESHOLD(THR), .LSB_FIRST(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en),
    .full(full_a), .almost_full(af_a), .prog_full(pf_a), .count(count_a),
    .rd_en(rd_en), .dout(dout_a), .empty(empty_a)
  );

  input_fifo_unpack #(
    .IN_WIDTH(IW), .RATIO(R), .DEPTH_LOG2(DL2),
    .PROG_FULL_THRESHOLD(THR), .LSB_FIRST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en),
    .full(full_b), .almost_full(af_b), .prog_full(pf_b), .count(count_b),
    .rd_en(rd_en), .dout(dout_b), .empty(empty_b)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words held, the edge each was written, the slice being
  // offered and the edge of the last retire. A word is visible two edges after
  // its write, but never before the previous word has been retired.
  typedef struct {
    logic [IW-1:0] w;
    int            t;
  } entry_t;

  entry_t mq[$];
  int     cyc;
  int     last_ret;
  int     mslice;
  int     errors;
  int     checks;

  function automatic bit m_empty();
    if (mq.size() == 0) return 1'b1;
    return (cyc < mq[0].t + 2) || (cyc < last_ret);
  endfunction

  function automatic logic [OW-1:0] m_dout(input bit msb);
    int            k;
    logic [IW-1:0] s;
    if (mq.size() == 0) return '0;
    k = msb ? (R - 1 - mslice) : mslice;
    s = mq[0].w >> (k * OW);
    return s[OW-1:0];
  endfunction

  function automatic logic [DL2:0] m_count();
    return (DL2 + 1)'(mq.size());
  endfunction

  // One clock of stimulus; returns at the following negedge with the model updated.
  task automatic step(input bit wr, input logic [IW-1:0] d, input bit rd);
    bit pre_empty;
    int pre_cnt;
    rst       = 1'b0;
    wr_en     = wr;
    din       = d;
    rd_en     = rd;
    pre_empty = m_empty();
    pre_cnt   = mq.size();
    @(posedge clk);
    cyc++;
    if (rd && !pre_empty) begin
      if (mslice == R - 1) begin
        void'(mq.pop_front());
        mslice   = 0;
        last_ret = cyc;
      end else begin
        mslice++;
      end
    end
    if (wr && pre_cnt < DEPTH) mq.push_back('{w: d, t: cyc});
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // One clock of reset with the given (ignored) write/read requests.
  task automatic reset_pulse(input bit wr, input bit rd);
    rst   = 1'b1;
    wr_en = wr;
    rd_en = rd;
    din   = IW'($urandom);
    @(posedge clk);
    cyc++;
    mq.delete();
    mslice   = 0;
    last_ret = cyc;
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_pulse(1'b1, 1'b1);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_a: got %b expected 1", empty_a); end
    checks++; if (empty_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_b: got %b expected 1", empty_b); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full_a); end
    checks++; if (af_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost_full: got %b expected 0", af_a); end
    checks++; if (pf_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_prog_full: got %b expected 0", pf_a); end
    checks++; if (count_a !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (dout_a !== '0) begin errors++; $display("[TB] FAIL reset_dout_a: got %h expected 00", dout_a); end
    checks++; if (dout_b !== '0) begin errors++; $display("[TB] FAIL reset_dout_b: got %h expected 00", dout_b); end
  endtask

  task automatic test_basic();
    reset_pulse(1'b0, 1'b0);
    step(1'b1, 16'hA1B2, 1'b0);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("[TB] FAIL basic_empty_t1: got %b expected 1", empty_a); end
    step(1'b0, '0, 1'b0);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("[TB] FAIL basic_empty_t2: got %b expected 1", empty_a); end
    step(1'b0, '0, 1'b0);
    checks++; if (empty_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_visible: got %b expected 0", empty_a); end
    checks++; if (dout_a !== 8'hB2) begin errors++; $display("[TB] FAIL basic_slice0: got %h expected b2", dout_a); end
    checks++; if (count_a !== 5'd1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", count_a); end
    step(1'b0, '0, 1'b1);
    checks++; if (dout_a !== 8'hA1) begin errors++; $display("[TB] FAIL basic_slice1: got %h expected a1", dout_a); end
    checks++; if (count_a !== 5'd1) begin errors++; $display("[TB] FAIL basic_count_mid: got %0d expected 1", count_a); end
    step(1'b0, '0, 1'b1);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("[TB] FAIL basic_drained: got %b expected 1", empty_a); end
    checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL basic_count_end: got %0d expected 0", count_a); end
  endtask

  task automatic test_msb_order();
    logic [OW-1:0] exp_seq [4];
    exp_seq[0] = 8'h12; exp_seq[1] = 8'h34; exp_seq[2] = 8'h56; exp_seq[3] = 8'h78;
    reset_pulse(1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (empty_b !== 1'b0) begin errors++; $display("[TB] FAIL msb_bubble[%0d]: got empty=%b expected 0", i, empty_b); end
      checks++; if (dout_b !== exp_seq[i]) begin errors++; $display("[TB] FAIL msb_seq[%0d]: got %h expected %h", i, dout_b, exp_seq[i]); end
      checks++; if (dout_a !== m_dout(1'b0)) begin errors++; $display("[TB] FAIL lsb_seq[%0d]: got %h expected %h", i, dout_a, m_dout(1'b0)); end
      step(1'b0, '0, 1'b1);
    end
    checks++; if (empty_b !== 1'b1) begin errors++; $display("[TB] FAIL msb_end_empty: got %b expected 1", empty_b); end
  endtask

  task automatic test_fill();
    reset_pulse(1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, IW'($urandom), 1'b0);
      checks++; if (count_a !== m_count()) begin errors++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, count_a, m_count()); end
      checks++; if (full_a !== (mq.size() == DEPTH)) begin errors++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, full_a, mq.size() == DEPTH); end
      checks++; if (af_a !== (mq.size() >= DEPTH - 1)) begin errors++; $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", i, af_a, mq.size() >= DEPTH - 1); end
      checks++; if (pf_a !== (mq.size() >= THR)) begin errors++; $display("[TB] FAIL fill_prog_full[%0d]: got %b expected %b", i, pf_a, mq.size() >= THR); end
    end
    checks++; if (count_a !== 5'd16) begin errors++; $display("[TB] FAIL fill_saturated: got %0d expected 16", count_a); end
    checks++; if (full_b !== 1'b1) begin errors++; $display("[TB] FAIL fill_full_b: got %b expected 1", full_b); end
    for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) begin
      checks++; if (empty_a !== m_empty()) begin errors++; $display("[TB] FAIL drain_empty[%0d]: got %b expected %b", i, empty_a, m_empty()); end
      if (!m_empty()) begin
        checks++; if (dout_a !== m_dout(1'b0)) begin errors++; $display("[TB] FAIL drain_dout_a[%0d]: got %h expected %h", i, dout_a, m_dout(1'b0)); end
        checks++; if (dout_b !== m_dout(1'b1)) begin errors++; $display("[TB] FAIL drain_dout_b[%0d]: got %h expected %h", i, dout_b, m_dout(1'b1)); end
      end
      step(1'b0, '0, 1'b1);
    end
    checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 0", count_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("[TB] FAIL drain_done: got %b expected 1", empty_a); end
  endtask

  task automatic test_prog_full();
    reset_pulse(1'b0, 1'b0);
    for (int i = 0; i < THR - 1; i++) step(1'b1, IW'($urandom), 1'b0);
    checks++; if (pf_a !== 1'b0) begin errors++; $display("[TB] FAIL pf_below: got %b expected 0", pf_a); end
    step(1'b1, IW'($urandom), 1'b0);
    checks++; if (pf_a !== 1'b1) begin errors++; $display("[TB] FAIL pf_at: got %b expected 1", pf_a); end
    step(1'b0, '0, 1'b1);
    checks++; if (pf_a !== 1'b1) begin errors++; $display("[TB] FAIL pf_partial: got %b expected 1", pf_a); end
    step(1'b0, '0, 1'b1);
    checks++; if (pf_a !== 1'b0) begin errors++; $display("[TB] FAIL pf_retired: got %b expected 0", pf_a); end
    checks++; if (count_a !== 5'd7) begin errors++; $display("[TB] FAIL pf_count: got %0d expected 7", count_a); end
  endtask

  task automatic test_full_collide();
    reset_pulse(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, IW'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    checks++; if (full_a !== 1'b1) begin errors++; $display("[TB] FAIL collide_pre_full: got %b expected 1", full_a); end
    step(1'b1, 16'hDEAD, 1'b1);
    checks++; if (count_a !== 5'd15) begin errors++; $display("[TB] FAIL collide_count: got %0d expected 15", count_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("[TB] FAIL collide_full: got %b expected 0", full_a); end
    checks++; if (af_a !== 1'b1) begin errors++; $display("[TB] FAIL collide_almost_full: got %b expected 1", af_a); end
    checks++; if (dout_a !== m_dout(1'b0)) begin errors++; $display("[TB] FAIL collide_next_word: got %h expected %h", dout_a, m_dout(1'b0)); end
  endtask

  task automatic test_reset_mid();
    reset_pulse(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, IW'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    reset_pulse(1'b1, 1'b1);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_empty: got %b expected 1", empty_a); end
    checks++; if (count_a !== 5'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", count_a); end
    checks++; if ({full_a, af_a, pf_a} !== 3'b000) begin errors++; $display("[TB] FAIL mid_flags: got %b expected 000", {full_a, af_a, pf_a}); end
    step(1'b1, 16'hCAFE, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++; if (dout_a !== 8'hFE) begin errors++; $display("[TB] FAIL mid_cafe_a: got %h expected fe", dout_a); end
    checks++; if (dout_b !== 8'hCA) begin errors++; $display("[TB] FAIL mid_cafe_b: got %h expected ca", dout_b); end
    checks++; if (count_a !== 5'd1) begin errors++; $display("[TB] FAIL mid_cafe_count: got %0d expected 1", count_a); end
  endtask

  task automatic test_random();
    bit wr;
    bit rd;
    reset_pulse(1'b0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      checks++; if (empty_a !== m_empty()) begin errors++; $display("[TB] FAIL rnd_empty_a[%0d]: got %b expected %b", i, empty_a, m_empty()); end
      checks++; if (empty_b !== m_empty()) begin errors++; $display("[TB] FAIL rnd_empty_b[%0d]: got %b expected %b", i, empty_b, m_empty()); end
      checks++; if (count_a !== m_count()) begin errors++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, count_a, m_count()); end
      checks++; if (full_a !== (mq.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd_full[%0d]: got %b expected %b", i, full_a, mq.size() == DEPTH); end
      checks++; if (af_a !== (mq.size() >= DEPTH - 1)) begin errors++; $display("[TB] FAIL rnd_almost_full[%0d]: got %b expected %b", i, af_a, mq.size() >= DEPTH - 1); end
      checks++; if (pf_b !== (mq.size() >= THR)) begin errors++; $display("[TB] FAIL rnd_prog_full[%0d]: got %b expected %b", i, pf_b, mq.size() >= THR); end
      if (!m_empty()) begin
        checks++; if (dout_a !== m_dout(1'b0)) begin errors++; $display("[TB] FAIL rnd_dout_a[%0d]: got %h expected %h", i, dout_a, m_dout(1'b0)); end
        checks++; if (dout_b !== m_dout(1'b1)) begin errors++; $display("[TB] FAIL rnd_dout_b[%0d]: got %h expected %h", i, dout_b, m_dout(1'b1)); end
      end
      if (i < 250) begin
        wr = ($urandom_range(99) < 75);
        rd = ($urandom_range(99) < 40);
      end else begin
        wr = ($urandom_range(99) < 30);
        rd = ($urandom_range(99) < 90);
      end
      step(wr, IW'($urandom), rd);
    end
  endtask

  // Test sequence.
  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    last_ret = 0;
    mslice   = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_msb_order();
    test_fill();
    test_prog_full();
    test_full_collide();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_fifo_unpack.md
Name: input_fifo_unpack

Overview:
Parametrised single-clock input FIFO that accepts IN_WIDTH-bit words and delivers them as RATIO narrower OUT_WIDTH-bit words in first-word fall-through (FWFT) form. It replaces the fixed 16-in/8-out input buffering at the front of the descrypt data path. It adds the following, all in one block with a registered output stage for timing:
- configurable width ratio and depth
- selectable unpack order
- programmable full threshold
- an occupancy count

Parameters:
IN_WIDTH, 16, input word width; must equal OUT_WIDTH*RATIO
RATIO, 2, output words per input word; 1, 2, 4 or 8
DEPTH_LOG2, 11, storage depth = 2**DEPTH_LOG2 input words (RAM plus output stage)
PROG_FULL_THRESHOLD, 1024, prog_full asserts when count >= this; range 1..DEPTH-1
LSB_FIRST, 1, 1: din[OUT_WIDTH-1:0] delivered first; 0: MS slice delivered first

Ports:
clk  in  1  single clock for both sides
rst  in  1  synchronous reset, active-high
din  in  IN_WIDTH  write data
wr_en  in  1  write request
full  out  1  no space; writes ignored
almost_full  out  1  count >= DEPTH-1
prog_full  out  1  count >= PROG_FULL_THRESHOLD
count  out  DEPTH_LOG2+1  input words held (RAM + partially/unread output word)
rd_en  in  1  read acknowledge (FWFT)
dout  out  IN_WIDTH/RATIO  current output word, valid while empty=0
empty  out  1  no output word available

Behaviour:
- Reset: when rst=1 at a clk edge, all pointers, count and the slice index clear.
  - Outputs after that edge: empty=1, full=0, almost_full=0, prog_full=0, count=0, dout=0.
  - wr_en/rd_en are ignored while rst=1.
  - Reset mid-operation discards all stored data; no partial word survives.
- Write: accepted at an edge when wr_en=1 and full=0. A write with full=1 is dropped; no state changes.
- Flags: full, almost_full, prog_full and count are registered and reflect state after the edge.
  - full = (count == 2**DEPTH_LOG2).
  - A simultaneous write and final-slice read while full=1: the write is still rejected; the read proceeds, and full drops next cycle.
- Storage: synchronous-read RAM of 2**DEPTH_LOG2 entries plus one IN_WIDTH output holding register. Prefetch moves RAM head into the holding register whenever the register is empty or its last slice is being read.
- Latency: a word written into an empty FIFO at edge t gives empty=0 after edge t+2, with dout = first slice.
- Read (FWFT): dout/empty are registered. rd_en=1 with empty=0 consumes the current slice; rd_en with empty=1 is ignored with no underflow.
  - Slice index counts 0..RATIO-1.
  - Slice k = din[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH] when LSB_FIRST=1; slice RATIO-1-k of that mapping when LSB_FIRST=0.
  - Reading slice RATIO-1 retires the input word: count decrements and the index wraps to 0.
  - If the next word is already prefetched, the new word's slice 0 appears on the next cycle with no bubble; otherwise empty=1.
- Back-to-back: sustained one output slice per clock while data is available. Input may sustain one word per RATIO clocks without filling.
- Count arithmetic: count += (write accepted) - (word retired). A simultaneous write and retire leaves count unchanged.
- Wrap-around: pointers are DEPTH_LOG2 bits and wrap modulo depth; no special handling at the wrap point.
- RATIO=1: the block degenerates to a plain FWFT FIFO with identical timing.

Test Plan:
- Reset, then write 16'hA1B2 at cycle 0 (LSB_FIRST=1, RATIO=2) -> empty=0 from cycle 2 with dout=8'hB2; rd_en -> dout=8'hA1; rd_en -> empty=1, count=0.
- LSB_FIRST=0, writes 16'h1234, 16'h5678, then continuous rd_en -> dout sequence 12,34,56,78 on consecutive cycles with no bubble between words.
- DEPTH_LOG2=4: write 16 words with no reads -> almost_full at count 15, full at 16; 17th write dropped; the read-back sequence equals the first 16 words exactly.
- PROG_FULL_THRESHOLD=8: fill to 7 -> prog_full=0; 8th write -> prog_full=1; retire one word -> prog_full=0.
- Full FIFO, write and final-slice read on the same edge -> write dropped, count=DEPTH-1, full=0 next cycle.
- Assert rst for one cycle mid-stream with 5 words stored and slice index=1 -> empty=1, count=0, flags=0. A subsequent write of 16'hCAFE yields dout=8'hFE first (LSB_FIRST=1).
